// File: rtl/cacheline_adaptor.sv
// Bridges a 256-bit cache line port to a 64-bit, 4-beat burst memory port.
// Handles line fills (read) and writebacks (write); one resp_o pulse per line.
module cacheline_adaptor #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned BURST_W = 64,
  parameter int unsigned BEATS   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W-1:0]          address_i,
  input  logic                       read_i,
  input  logic                       write_i,
  input  logic [BURST_W*BEATS-1:0]   line_i,
  output logic [BURST_W*BEATS-1:0]   line_o,
  output logic                       resp_o,
  output logic [ADDR_W-1:0]          address_o,
  output logic                       read_o,
  output logic                       write_o,
  input  logic [BURST_W-1:0]         burst_i,
  output logic [BURST_W-1:0]         burst_o,
  input  logic                       resp_i
);

  localparam int unsigned LineW = BURST_W * BEATS;
  localparam int unsigned CntW  = $clog2(BEATS);
  localparam int unsigned OffW  = $clog2(LineW / 8);
  localparam logic [ADDR_W-1:0] OffMask = ADDR_W'((1 << OffW) - 1);
  localparam logic [CntW-1:0]   LastBeat = CntW'(BEATS - 1);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d, cnt_nxt;
  logic [LineW-1:0]    line_q, line_d;
  logic [LineW-1:0]    wline_q, wline_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BURST_W-1:0]  burst_q, burst_d;
  logic                read_q, read_d;
  logic                write_q, write_d;
  logic                resp_q, resp_d;

  assign cnt_nxt = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    wline_d = wline_q;
    addr_d  = addr_q;
    burst_d = burst_q;
    read_d  = read_q;
    write_d = write_q;
    resp_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Writeback wins over fill when both are requested.
        if (write_i) begin
          wline_d = line_i;
          addr_d  = address_i & ~OffMask;
          cnt_d   = '0;
          burst_d = line_i[BURST_W-1:0];
          write_d = 1'b1;
          state_d = StWrite;
        end else if (read_i) begin
          addr_d  = address_i & ~OffMask;
          cnt_d   = '0;
          read_d  = 1'b1;
          state_d = StRead;
        end
      end
      StRead: begin
        if (resp_i) begin
          line_d[int'(cnt_q)*BURST_W +: BURST_W] = burst_i;
          if (cnt_q == LastBeat) begin
            cnt_d   = '0;
            read_d  = 1'b0;
            resp_d  = 1'b1;
            state_d = StDone;
          end else begin
            cnt_d = cnt_nxt;
          end
        end
      end
      StWrite: begin
        if (resp_i) begin
          if (cnt_q == LastBeat) begin
            cnt_d   = '0;
            write_d = 1'b0;
            resp_d  = 1'b1;
            state_d = StDone;
          end else begin
            cnt_d   = cnt_nxt;
            burst_d = wline_q[int'(cnt_nxt)*BURST_W +: BURST_W];
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      line_q  <= '0;
      wline_q <= '0;
      addr_q  <= '0;
      burst_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      wline_q <= wline_d;
      addr_q  <= addr_d;
      burst_q <= burst_d;
      read_q  <= read_d;
      write_q <= write_d;
      resp_q  <= resp_d;
    end
  end

  assign line_o    = line_q;
  assign resp_o    = resp_q;
  assign address_o = addr_q;
  assign read_o    = read_q;
  assign write_o   = write_q;
  assign burst_o   = burst_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: a transaction-level model is compared
// against the DUT every cycle, with literal spot checks on key results.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [31:0]  address_i = '0;
  logic         read_i = 1'b0;
  logic         write_i = 1'b0;
  logic [255:0] line_i = '0;
  logic [255:0] line_o;
  logic         resp_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic [63:0]  burst_i = '0;
  logic [63:0]  burst_o;
  logic         resp_i = 1'b0;

  int tests = 0;
  int fails = 0;
  int n_read_cyc = 0;
  int n_write_cyc = 0;
  int n_resp = 0;
  bit started = 1'b0;

  cacheline_adaptor #(.ADDR_W(32), .BURST_W(64), .BEATS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .line_i    (line_i),
    .line_o    (line_o),
    .resp_o    (resp_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction model: 0 idle, 1 filling, 2 writing back, 3 responding.
  int          m_kind = 0;
  int          m_beats = 0;
  logic [63:0] m_line [4] = '{default: '0};
  logic [63:0] m_wl   [4] = '{default: '0};
  logic [31:0] m_addr = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_kind  = 0;
      m_beats = 0;
      m_addr  = '0;
      for (int i = 0; i < 4; i++) begin
        m_line[i] = '0;
        m_wl[i]   = '0;
      end
    end else begin
      case (m_kind)
        0: begin
          if (write_i || read_i) begin
            m_addr  = address_i & 32'hFFFF_FFE0;
            m_beats = 0;
            m_kind  = write_i ? 2 : 1;
            for (int i = 0; i < 4; i++) m_wl[i] = line_i[i*64 +: 64];
          end
        end
        1: if (resp_i) begin
          m_line[m_beats] = burst_i;
          m_beats++;
          if (m_beats == 4) m_kind = 3;
        end
        2: if (resp_i) begin
          m_beats++;
          if (m_beats == 4) m_kind = 3;
        end
        default: m_kind = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("cyc_line_o", line_o, {m_line[3], m_line[2], m_line[1], m_line[0]});
      check("cyc_resp_o", resp_o, m_kind == 3);
      check("cyc_read_o", read_o, m_kind == 1);
      check("cyc_write_o", write_o, m_kind == 2);
      check("cyc_address_o", address_o, m_addr);
      if (m_kind == 2) check("cyc_burst_o", burst_o, m_wl[m_beats]);
      if (read_o) n_read_cyc++;
      if (write_o) n_write_cyc++;
      if (resp_o) n_resp++;
    end
  end

  // Drives one fill; pat bit j is resp_i for the j-th cycle after acceptance.
  task automatic do_read(input logic [31:0] addr, input logic [255:0] line,
                         input logic [7:0] pat, input int plen);
    int b = 0;
    int rc0 = n_read_cyc;
    int rs0 = n_resp;
    @(posedge clk); #1;
    address_i = addr; read_i = 1'b1; resp_i = 1'b0;
    @(posedge clk); #1;
    check("rd_addr", address_o, addr & 32'hFFFF_FFE0);
    address_i = 32'hFFFF_FFFF;
    for (int j = 0; j < plen; j++) begin
      resp_i  = pat[j];
      burst_i = pat[j] ? line[b*64 +: 64] : 64'hFFFF_0000_DEAD_BEEF;
      if (pat[j]) b++;
      @(posedge clk); #1;
    end
    resp_i = 1'b0; read_i = 1'b0;
    check("rd_resp_pulse", resp_o, 1'b1);
    @(posedge clk); #1;
    check("rd_resp_end", resp_o, 1'b0);
    check("rd_line", line_o, line);
    check("rd_read_cycles", n_read_cyc - rc0, plen);
    check("rd_resp_count", n_resp - rs0, 1);
  endtask

  task automatic do_write(input logic [255:0] line, input logic also_read);
    int rc0 = n_read_cyc;
    int wc0 = n_write_cyc;
    int rs0 = n_resp;
    @(posedge clk); #1;
    address_i = 32'h0000_ABCD; line_i = line; write_i = 1'b1; read_i = also_read;
    @(posedge clk); #1;
    line_i = '1;
    for (int j = 0; j < 4; j++) begin
      check("wr_burst_beat", burst_o, line[j*64 +: 64]);
      resp_i = 1'b1;
      @(posedge clk); #1;
    end
    resp_i = 1'b0; write_i = 1'b0; read_i = 1'b0;
    check("wr_resp_pulse", resp_o, 1'b1);
    check("wr_write_low", write_o, 1'b0);
    @(posedge clk); #1;
    check("wr_write_cycles", n_write_cyc - wc0, 4);
    check("wr_no_read", n_read_cyc - rc0, 0);
    check("wr_resp_count", n_resp - rs0, 1);
  endtask

  localparam logic [255:0] LineA = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
  localparam logic [255:0] LineB = {64'hB3B3_0000_0000_0003, 64'hB2B2_0000_0000_0002,
                                    64'hB1B1_0000_0000_0001, 64'hB0B0_0000_0000_0000};
  localparam logic [255:0] LineD = {64'hD3D3_D3D3_D3D3_D3D3, 64'hD2D2_D2D2_D2D2_D2D2,
                                    64'hD1D1_D1D1_D1D1_D1D1, 64'hD0D0_D0D0_D0D0_D0D0};
  localparam logic [255:0] LineE = {64'hE3, 64'hE2, 64'hE1, 64'hE0};
  localparam logic [255:0] LineC = {64'hC3, 64'hC2, 64'hC1, 64'hC0};

  initial begin
    int rs0;
    @(posedge clk); #1;
    started = 1'b1;
    check("rst_line_o", line_o, '0);
    check("rst_outputs", {resp_o, read_o, write_o, address_o, burst_o}, '0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Read without wait states; 0x1234 aligns down to 0x1220.
    do_read(32'h0000_1234, LineA, 8'h0F, 4);
    check("lit_addr_1220", address_o, 32'h0000_1220);
    check("lit_lineA", line_o, 256'h00000000000000a3_00000000000000a2_00000000000000a1_00000000000000a0);

    // Read with stalls: resp_i = 1,0,0,1,0,1,1.
    do_read(32'h8000_00FF, LineB, 8'h69, 7);

    // Plain writeback, then simultaneous read+write request.
    do_write(LineD, 1'b0);
    check("lit_line_kept", line_o, LineB);
    do_write(LineE, 1'b1);

    // Mid-burst reset after two beats of a fill.
    rs0 = n_resp;
    @(posedge clk); #1;
    address_i = 32'h0000_4000; read_i = 1'b1;
    @(posedge clk); #1;
    resp_i = 1'b1; burst_i = 64'h11;
    @(posedge clk); #1;
    burst_i = 64'h22;
    @(posedge clk); #1;
    resp_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("arst_line_o", line_o, '0);
    check("arst_outputs", {resp_o, read_o, write_o, address_o, burst_o}, '0);
    read_i = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    check("arst_no_resp", n_resp - rs0, 0);
    do_read(32'h0000_5010, LineC, 8'h0F, 4);

    // Stray resp_i while idle.
    rs0 = n_resp;
    resp_i = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("stray_resp_o", resp_o, 1'b0);
      check("stray_read_o", read_o, 1'b0);
    end
    resp_i = 1'b0;
    @(posedge clk); #1;
    check("stray_line_kept", line_o, LineC);
    check("stray_resp_count", n_resp - rs0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
